// File: rtl/ddr_resp_model_if.sv
`default_nettype none
// ddr_resp_model_if: DDR request/response channel between the core and its responder.
// Revision: 1.0
interface ddr_resp_model_if;
  logic         ddr_chip_enable;
  logic [63:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [511:0] ddr_write_mask;
  logic [511:0] ddr_write_data;
  logic [511:0] ddr_read_data;
  logic         ddr_operation_done;
  logic         ddr_ready;

  modport master (
    output ddr_chip_enable,
    output ddr_index,
    output ddr_write_enable,
    output ddr_burst_mode,
    output ddr_write_mask,
    output ddr_write_data,
    input  ddr_read_data,
    input  ddr_operation_done,
    input  ddr_ready
  );

  modport slave (
    input  ddr_chip_enable,
    input  ddr_index,
    input  ddr_write_enable,
    input  ddr_burst_mode,
    input  ddr_write_mask,
    input  ddr_write_data,
    output ddr_read_data,
    output ddr_operation_done,
    output ddr_ready
  );
endinterface
`default_nettype wire

// File: rtl/ddr_resp_model.sv
`default_nettype none
// ddr_resp_model: fixed-latency DDR responder backed by a 512-bit-line memory.
// Revision: 1.0
module ddr_resp_model #(
  parameter int LINES   = 1024,
  parameter int LATENCY = 4
) (
  input  logic            clock,
  input  logic            reset,
  ddr_resp_model_if.slave ddr
);
  localparam int LINE_W = $clog2(LINES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               done_q;
  logic [511:0]       rdata_q;

  logic [LINE_W-1:0]  line_q;
  logic [2:0]         lane_q;
  logic               we_q;
  logic               burst_q;
  logic [511:0]       mask_q;
  logic [511:0]       data_q;

  logic [511:0]       mem [LINES];

  logic               accept;
  logic               fire;
  logic [LINE_W-1:0]  op_line;
  logic [2:0]         op_lane;
  logic               op_we;
  logic               op_burst;
  logic [511:0]       op_mask;
  logic [511:0]       op_data;
  logic [511:0]       mem_line;
  logic [63:0]        lane_dw;
  logic [511:0]       rdata_d;
  logic               unused_idx;

  assign accept = ready_q && ddr.ddr_chip_enable;

  // Counter holds cycles left including the current one; the access happens on the
  // edge closing the last BUSY cycle so done lands exactly LATENCY cycles after accept.
  // With LATENCY=1 that edge is the accept edge itself, so the live request is used.
  assign fire = (LATENCY == 1) ? accept
                               : ((state_q == BUSY) && (cnt_q == CNT_LAST));

  assign op_line  = (state_q == IDLE) ? ddr.ddr_index[6 +: LINE_W] : line_q;
  assign op_lane  = (state_q == IDLE) ? ddr.ddr_index[5:3]         : lane_q;
  assign op_we    = (state_q == IDLE) ? ddr.ddr_write_enable       : we_q;
  assign op_burst = (state_q == IDLE) ? ddr.ddr_burst_mode         : burst_q;
  assign op_mask  = (state_q == IDLE) ? ddr.ddr_write_mask         : mask_q;
  assign op_data  = (state_q == IDLE) ? ddr.ddr_write_data         : data_q;

  assign mem_line = mem[op_line];
  assign lane_dw  = mem_line[{op_lane, 6'd0} +: 64];
  assign rdata_d  = op_burst ? mem_line : {448'd0, lane_dw};

  assign unused_idx = ^{ddr.ddr_index[63:6+LINE_W], ddr.ddr_index[2:0]};

  // Memory is deliberately outside reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && fire && op_we) begin
      mem[op_line] <= (mem[op_line] & ~op_mask) | (op_data & op_mask);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= '0;
      line_q  <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            line_q  <= ddr.ddr_index[6 +: LINE_W];
            lane_q  <= ddr.ddr_index[5:3];
            we_q    <= ddr.ddr_write_enable;
            burst_q <= ddr.ddr_burst_mode;
            mask_q  <= ddr.ddr_write_mask;
            data_q  <= ddr.ddr_write_data;
            if (fire) begin
              done_q <= 1'b1;
              if (!op_we) begin
                rdata_q <= rdata_d;
              end
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_LOAD;
              ready_q <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (fire) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            if (!op_we) begin
              rdata_q <= rdata_d;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ddr.ddr_ready          = ready_q;
  assign ddr.ddr_operation_done = done_q;
  assign ddr.ddr_read_data      = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_ddr_resp_model.sv
`default_nettype none
// tb_ddr_resp_model: randomized and directed checks of ddr_resp_model against a line-level model.
// Revision: 1.0
module tb_ddr_resp_model;
  localparam int LINES   = 1024;
  localparam int LATENCY = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ddr_resp_model_if ddr ();
  ddr_resp_model_if ddr1 ();

  ddr_resp_model #(.LINES(LINES), .LATENCY(LATENCY)) dut (
    .clock (clock),
    .reset (reset),
    .ddr   (ddr)
  );

  ddr_resp_model #(.LINES(16), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .ddr   (ddr1)
  );

  int total = 0;
  int bad   = 0;

  logic [511:0] mem_m [int];
  logic [511:0] exp_rd;

  int           obs_lat;
  int           obs_low;
  int           obs_done;
  logic [511:0] obs_rd;

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: a line is addressed by (byte index / 64) mod LINES, a dword by (index / 8) mod 8.
  function automatic void model_apply(input logic we, input logic burst, input logic [63:0] idx,
                                      input logic [511:0] mask, input logic [511:0] data);
    int line;
    int lane;
    logic [511:0] cur;
    line = int'((idx / 64) % LINES);
    lane = int'((idx / 8) % 8);
    cur  = mem_m.exists(line) ? mem_m[line] : 'x;
    if (we) mem_m[line] = (cur & ~mask) | (data & mask);
    else if (burst) exp_rd = cur;
    else begin
      exp_rd = '0;
      exp_rd[63:0] = cur[lane*64 +: 64];
    end
  endfunction

  // Issues one request and records latency, ready-low cycles, done pulses and data at done.
  task automatic run_req(input logic we, input logic burst, input logic [63:0] idx,
                         input logic [511:0] mask, input logic [511:0] data,
                         input int inject_at, input int rst_at);
    @(negedge clock);
    ddr.ddr_chip_enable  = 1'b1;
    ddr.ddr_write_enable = we;
    ddr.ddr_burst_mode   = burst;
    ddr.ddr_index        = idx;
    ddr.ddr_write_mask   = mask;
    ddr.ddr_write_data   = data;
    @(posedge clock); #1;
    ddr.ddr_chip_enable  = 1'b0;
    ddr.ddr_index        = ~idx;
    ddr.ddr_write_data   = ~data;
    ddr.ddr_write_mask   = ~mask;
    ddr.ddr_write_enable = ~we;
    obs_lat  = 0;
    obs_low  = 0;
    obs_done = 0;
    obs_rd   = 'x;
    for (int k = 1; k <= LATENCY + 3; k++) begin
      if (k == inject_at) begin
        ddr.ddr_chip_enable  = 1'b1;
        ddr.ddr_write_enable = 1'b1;
        ddr.ddr_index        = idx;
        ddr.ddr_write_mask   = '1;
      end else if (k == inject_at + 1) begin
        ddr.ddr_chip_enable  = 1'b0;
      end
      if (k == rst_at) reset = 1'b1;
      else if (k == rst_at + 1) reset = 1'b0;
      if (ddr.ddr_operation_done === 1'b1) begin
        obs_done++;
        if (obs_lat == 0) begin
          obs_lat = k;
          obs_rd  = ddr.ddr_read_data;
        end
      end
      if (obs_lat == 0 && ddr.ddr_ready !== 1'b1) obs_low++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    total++; if (ddr.ddr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ddr.ddr_ready); end
    total++; if (ddr.ddr_operation_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ddr.ddr_operation_done); end
    total++; if (ddr.ddr_read_data !== 512'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", ddr.ddr_read_data); end
    exp_rd = '0;
  endtask

  task automatic test_full_write_burst_read();
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = 64'hDEADBEEF_00000000 + 64'(k);
    for (int op = 0; op < 2; op++) begin
      run_req(op == 0, 1'b1, 64'h1040, '1, d, 0, 0);
      model_apply(op == 0, 1'b1, 64'h1040, '1, d);
      total++; if (obs_lat !== LATENCY) begin bad++; $display("FAIL full_lat[%0d]: got %0d want %0d", op, obs_lat, LATENCY); end
      total++; if (obs_low !== LATENCY - 1) begin bad++; $display("FAIL full_ready_low[%0d]: got %0d want %0d", op, obs_low, LATENCY - 1); end
      total++; if (obs_done !== 1) begin bad++; $display("FAIL full_done_cnt[%0d]: got %0d want 1", op, obs_done); end
      total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL full_rdata[%0d]: got %h want %h", op, obs_rd, exp_rd); end
    end
    total++; if (obs_rd !== d) begin bad++; $display("FAIL full_line: got %h want %h", obs_rd, d); end
  endtask

  task automatic test_partial_write();
    logic [511:0] m;
    logic [511:0] d;
    run_req(1'b1, 1'b0, 64'h40, '1, '0, 0, 0);
    model_apply(1'b1, 1'b0, 64'h40, '1, '0);
    m = '0;
    m[191:128] = 64'hFFFF;
    d = rand512();
    d[191:128] = 64'h1234_5678_9ABC_DEF0;
    run_req(1'b1, 1'b1, 64'h40, m, d, 0, 0);
    model_apply(1'b1, 1'b1, 64'h40, m, d);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL partial_wr_hold: got %h want %h", obs_rd, exp_rd); end
    run_req(1'b0, 1'b0, 64'h50, '0, '0, 0, 0);
    model_apply(1'b0, 1'b0, 64'h50, '0, '0);
    total++; if (obs_rd !== {448'd0, 64'h0000_0000_0000_DEF0}) begin bad++; $display("FAIL partial_rdata: got %h want DEF0", obs_rd); end
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL partial_model: got %h want %h", obs_rd, exp_rd); end
  endtask

  task automatic test_busy_request();
    run_req(1'b0, 1'b1, 64'h40, '0, rand512(), 2, 0);
    model_apply(1'b0, 1'b1, 64'h40, '0, '0);
    total++; if (obs_done !== 1) begin bad++; $display("FAIL busy_done_cnt: got %0d want 1", obs_done); end
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL busy_rdata: got %h want %h", obs_rd, exp_rd); end
    run_req(1'b0, 1'b1, 64'h40, '0, '0, 0, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL busy_line_kept: got %h want %h", obs_rd, exp_rd); end
  endtask

  task automatic test_address_wrap();
    logic [511:0] d;
    d = rand512();
    run_req(1'b1, 1'b1, 64'h10000, '1, d, 0, 0);
    model_apply(1'b1, 1'b1, 64'h10000, '1, d);
    run_req(1'b0, 1'b1, 64'h0, '0, '0, 0, 0);
    model_apply(1'b0, 1'b1, 64'h0, '0, '0);
    total++; if (obs_rd !== d) begin bad++; $display("FAIL wrap_rdata: got %h want %h", obs_rd, d); end
  endtask

  task automatic test_reset_midop();
    logic [511:0] prior;
    prior = rand512();
    run_req(1'b1, 1'b1, 64'hC0, '1, prior, 0, 0);
    model_apply(1'b1, 1'b1, 64'hC0, '1, prior);
    run_req(1'b1, 1'b1, 64'hC0, '1, {64{8'hA5}}, 0, 2);
    exp_rd = '0;
    total++; if (obs_done !== 0) begin bad++; $display("FAIL midrst_done_cnt: got %0d want 0", obs_done); end
    total++; if (ddr.ddr_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", ddr.ddr_ready); end
    total++; if (ddr.ddr_read_data !== 512'd0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", ddr.ddr_read_data); end
    run_req(1'b0, 1'b1, 64'hC0, '0, '0, 0, 0);
    model_apply(1'b0, 1'b1, 64'hC0, '0, '0);
    total++; if (obs_rd !== prior) begin bad++; $display("FAIL midrst_prior: got %h want %h", obs_rd, prior); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] d;
    int lat;
    d = rand512();
    @(negedge clock);
    ddr.ddr_chip_enable  = 1'b1;
    ddr.ddr_write_enable = 1'b1;
    ddr.ddr_burst_mode   = 1'b0;
    ddr.ddr_index        = 64'h140;
    ddr.ddr_write_mask   = '1;
    ddr.ddr_write_data   = d;
    @(posedge clock); #1;
    ddr.ddr_chip_enable  = 1'b0;
    lat = 0;
    for (int k = 1; k <= LATENCY + 3 && lat == 0; k++) begin
      if (ddr.ddr_operation_done === 1'b1) lat = k;
      else begin @(posedge clock); #1; end
    end
    total++; if (lat !== LATENCY) begin bad++; $display("FAIL b2b_wr_lat: got %0d want %0d", lat, LATENCY); end
    total++; if (ddr.ddr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_done: got %b want 1", ddr.ddr_ready); end
    ddr.ddr_chip_enable  = 1'b1;
    ddr.ddr_write_enable = 1'b0;
    ddr.ddr_burst_mode   = 1'b1;
    @(posedge clock); #1;
    ddr.ddr_chip_enable  = 1'b0;
    lat = 0;
    for (int k = 1; k <= LATENCY + 3 && lat == 0; k++) begin
      if (ddr.ddr_operation_done === 1'b1) lat = k;
      else begin @(posedge clock); #1; end
    end
    total++; if (lat !== LATENCY) begin bad++; $display("FAIL b2b_rd_lat: got %0d want %0d", lat, LATENCY); end
    total++; if (ddr.ddr_read_data !== d) begin bad++; $display("FAIL b2b_rdata: got %h want %h", ddr.ddr_read_data, d); end
    model_apply(1'b1, 1'b0, 64'h140, '1, d);
    model_apply(1'b0, 1'b1, 64'h140, '0, '0);
  endtask

  task automatic test_random();
    logic [63:0]  idx;
    logic [511:0] m;
    logic [511:0] d;
    logic         we;
    logic         burst;
    for (int l = 0; l < 8; l++) begin
      d = rand512();
      run_req(1'b1, 1'b0, 64'(l * 64), '1, d, 0, 0);
      model_apply(1'b1, 1'b0, 64'(l * 64), '1, d);
    end
    for (int i = 0; i < 40; i++) begin
      idx = {$urandom, $urandom};
      idx[15:9] = '0;
      we    = 1'($urandom_range(0, 1));
      burst = 1'($urandom_range(0, 1));
      m     = ($urandom_range(0, 1) == 1) ? rand512() : '1;
      d     = rand512();
      run_req(we, burst, idx, m, d, 0, 0);
      model_apply(we, burst, idx, m, d);
      total++; if (obs_lat !== LATENCY) begin bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, obs_lat, LATENCY); end
      total++; if (obs_low !== LATENCY - 1) begin bad++; $display("FAIL rand_ready_low[%0d]: got %0d want %0d", i, obs_low, LATENCY - 1); end
      total++; if (obs_done !== 1) begin bad++; $display("FAIL rand_done_cnt[%0d]: got %0d want 1", i, obs_done); end
      total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, obs_rd, exp_rd); end
    end
  endtask

  task automatic test_latency_one();
    logic [511:0] d;
    d = rand512();
    @(negedge clock);
    ddr1.ddr_chip_enable  = 1'b1;
    ddr1.ddr_write_enable = 1'b1;
    ddr1.ddr_burst_mode   = 1'b0;
    ddr1.ddr_index        = 64'h80;
    ddr1.ddr_write_mask   = '1;
    ddr1.ddr_write_data   = d;
    @(posedge clock); #1;
    ddr1.ddr_chip_enable  = 1'b0;
    total++; if (ddr1.ddr_operation_done !== 1'b1) begin bad++; $display("FAIL lat1_wr_done: got %b want 1", ddr1.ddr_operation_done); end
    total++; if (ddr1.ddr_ready !== 1'b1) begin bad++; $display("FAIL lat1_ready: got %b want 1", ddr1.ddr_ready); end
    @(posedge clock); #1;
    total++; if (ddr1.ddr_operation_done !== 1'b0) begin bad++; $display("FAIL lat1_done_pulse: got %b want 0", ddr1.ddr_operation_done); end
    @(negedge clock);
    ddr1.ddr_chip_enable  = 1'b1;
    ddr1.ddr_write_enable = 1'b0;
    ddr1.ddr_burst_mode   = 1'b1;
    @(posedge clock); #1;
    ddr1.ddr_chip_enable  = 1'b0;
    total++; if (ddr1.ddr_operation_done !== 1'b1) begin bad++; $display("FAIL lat1_rd_done: got %b want 1", ddr1.ddr_operation_done); end
    total++; if (ddr1.ddr_read_data !== d) begin bad++; $display("FAIL lat1_rdata: got %h want %h", ddr1.ddr_read_data, d); end
  endtask

  initial begin
    ddr.ddr_chip_enable   = 1'b0;
    ddr.ddr_index         = '0;
    ddr.ddr_write_enable  = 1'b0;
    ddr.ddr_burst_mode    = 1'b0;
    ddr.ddr_write_mask    = '0;
    ddr.ddr_write_data    = '0;
    ddr1.ddr_chip_enable  = 1'b0;
    ddr1.ddr_index        = '0;
    ddr1.ddr_write_enable = 1'b0;
    ddr1.ddr_burst_mode   = 1'b0;
    ddr1.ddr_write_mask   = '0;
    ddr1.ddr_write_data   = '0;
    exp_rd = '0;
    test_reset();
    test_full_write_burst_read();
    test_partial_write();
    test_busy_request();
    test_address_wrap();
    test_reset_midop();
    test_back_to_back();
    test_random();
    test_latency_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
